univ_shift_reg: RTL and testbench

Parametrised universal shift register: the WIDTH-generic successor to the 4-bit HC194 block in the HC-series logic library. It keeps the HC194 hold, shift-right, shift-left and parallel-load modes with the same mode encoding. It adds rotate, arithmetic-shift and synchronous-clear modes, plus an auto-burst engine that runs a programmed number of shifts under a Start/Busy/Done handshake. It sits wherever the HC194 was used when a wider word or multi-bit shifting is needed.

---
 rtl/univ_shift_reg_pkg.sv | 27 ++
 rtl/univ_shift_reg_if.sv | 29 ++
 rtl/univ_shift_reg_shift_core.sv | 45 ++++
 rtl/univ_shift_reg.sv | 76 +++++++
 tb/tb_univ_shift_reg.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings, FSM states
// and the shift-mode classification used to qualify burst requests.
package univ_shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SR   = 3'b001,
    MODE_SL   = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASL  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Only modes that move bits are worth repeating in a burst.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SR) || (m == MODE_SL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register; the client drives mode,
// serial/parallel data and burst requests, the register returns its state.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2:0]       S;
  logic             DSR;
  logic             DSL;
  logic [WIDTH-1:0] D;
  logic             Start;
  logic [CW-1:0]    Cnt;
  logic [WIDTH-1:0] Q;
  logic             SOR;
  logic             SOL;
  logic             Busy;
  logic             Done;

  modport master (
    output S, DSR, DSL, D, Start, Cnt,
    input  Q, SOR, SOL, Busy, Done
  );

  modport slave (
    input  S, DSR, DSL, D, Start, Cnt,
    output Q, SOR, SOL, Busy, Done
  );
endinterface

// File: rtl/univ_shift_reg_shift_core.sv
// Combinational next-state function of the shift register, shared by the
// direct path and the burst engine.
module shift_core
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             dsr,
  input  logic             dsl,
  output logic [WIDTH-1:0] q_next
);

  // q_up: bits moved one place toward the higher index; q_dn: toward index 0.
  logic [WIDTH-1:1] q_up;
  logic [WIDTH-2:0] q_dn;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_up
      assign q_up[gi] = q[gi-1];
    end
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_dn
      assign q_dn[gi] = q[gi+1];
    end
  endgenerate

  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_SR:   q_next = {q_up, dsr};
      MODE_SL:   q_next = {dsl, q_dn};
      MODE_LOAD: q_next = d;
      MODE_ROR:  q_next = {q_up, q[WIDTH-1]};
      MODE_ROL:  q_next = {q[0], q_dn};
      MODE_ASL:  q_next = {q[WIDTH-1], q_dn};
      MODE_CLR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-generic universal shift register (HC194 superset) with an auto-burst
// engine that repeats a latched shift mode Cnt times under Start/Busy/Done.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              Clk,
  input logic              MR,
  univ_shift_reg_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  state_e           state_reg;
  mode_e            mode_reg;
  logic [CW-1:0]    remain_reg;
  logic             done_reg;
  mode_e            core_mode;
  logic             accept;

  // A Start with a non-shift mode or a zero count degrades to a direct operation.
  assign accept    = bus.Start && is_shift_mode(bus.S) && (bus.Cnt != '0);
  assign core_mode = (state_reg == ST_BURST) ? mode_reg : mode_e'(bus.S);

  shift_core #(.WIDTH(WIDTH)) u_core (
    .mode   (core_mode),
    .q      (q_reg),
    .d      (bus.D),
    .dsr    (bus.DSR),
    .dsl    (bus.DSL),
    .q_next (q_next)
  );

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      q_reg      <= '0;
      state_reg  <= ST_IDLE;
      mode_reg   <= MODE_HOLD;
      remain_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            // Q holds on the accepting edge; shifting starts on the next one.
            mode_reg   <= mode_e'(bus.S);
            remain_reg <= bus.Cnt;
            state_reg  <= ST_BURST;
          end else begin
            q_reg <= q_next;
          end
        end
        ST_BURST: begin
          q_reg      <= q_next;
          remain_reg <= remain_reg - CW'(1);
          if (remain_reg == CW'(1)) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.Q    = q_reg;
  assign bus.SOR  = q_reg[WIDTH-1];
  assign bus.SOL  = q_reg[0];
  assign bus.Busy = (state_reg == ST_BURST);
  assign bus.Done = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): directed scenarios plus
// randomized traffic against an arithmetic/queue reference model.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic clk = 1'b0;
  logic mr;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W)) dut (
    .Clk (clk),
    .MR  (mr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ntx    = 0;

  // Reference model: register value plus a queue of modes still owed by a burst.
  int         mq = 0;
  logic [2:0] pend[$];
  logic       exp_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_is_shift(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd2) || (s == 3'd4) || (s == 3'd5) || (s == 3'd6);
  endfunction

  // Index 0 is the LSB; "right" multiplies by two, "left" divides by two.
  function automatic int apply(input logic [2:0] m, input int v, input int dsr,
                               input int dsl, input int d);
    case (m)
      3'd0:    return v;
      3'd1:    return (v * 2 + dsr) % 256;
      3'd2:    return v / 2 + dsl * 128;
      3'd3:    return d;
      3'd4:    return (v * 2) % 256 + v / 128;
      3'd5:    return v / 2 + (v % 2) * 128;
      3'd6:    return v / 2 + (v / 128) * 128;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] s, input logic [7:0] d, input logic dsr,
                       input logic dsl, input logic start, input int cnt);
    bus.S     = s;
    bus.D     = d;
    bus.DSR   = dsr;
    bus.DSL   = dsl;
    bus.Start = start;
    bus.Cnt   = 4'(cnt);
  endtask

  // One clock edge with MR high: advance the model, then compare all outputs.
  task automatic cycle();
    logic [2:0] m;
    if (pend.size() > 0) begin
      m        = pend.pop_front();
      mq       = apply(m, mq, int'(bus.DSR), int'(bus.DSL), int'(bus.D));
      exp_done = (pend.size() == 0);
    end else begin
      exp_done = 1'b0;
      if (bus.Start && model_is_shift(bus.S) && bus.Cnt != 0) begin
        for (int i = 0; i < int'(bus.Cnt); i++) pend.push_back(bus.S);
      end else begin
        mq = apply(bus.S, mq, int'(bus.DSR), int'(bus.DSL), int'(bus.D));
      end
    end
    @(posedge clk);
    #1;
    ntx++;
    $display("txn %0d S=%0b start=%0b cnt=%0d Q=%02h busy=%0b done=%0b",
             ntx, bus.S, bus.Start, bus.Cnt, bus.Q, bus.Busy, bus.Done);
    chk("q", 32'(bus.Q), 32'(mq));
    chk("sor", 32'(bus.SOR), 32'(mq / 128));
    chk("sol", 32'(bus.SOL), 32'(mq % 2));
    chk("busy", 32'(bus.Busy), 32'(pend.size() != 0));
    chk("done", 32'(bus.Done), 32'(exp_done));
  endtask

  // Assert MR between edges, check the immediate effect, hold across one edge.
  task automatic pulse_reset();
    mr = 1'b0;
    #2;
    chk("rst_q", 32'(bus.Q), 32'h0);
    chk("rst_busy", 32'(bus.Busy), 32'h0);
    chk("rst_done", 32'(bus.Done), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_q", 32'(bus.Q), 32'h0);
    mq = 0;
    pend.delete();
    exp_done = 1'b0;
    mr = 1'b1;
  endtask

  initial begin
    mr = 1'b0;
    drive(3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 0);

    // Reset dominates a pending load while the clock runs.
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("por_q", 32'(bus.Q), 32'h0);
      chk("por_busy", 32'(bus.Busy), 32'h0);
      chk("por_done", 32'(bus.Done), 32'h0);
      chk("por_sor", 32'(bus.SOR), 32'h0);
    end
    mr = 1'b1;
    cycle();
    chk("load_a5", 32'(bus.Q), 32'hA5);

    // HC194-compatible modes
    drive(3'b001, 8'h00, 1'b1, 1'b0, 1'b0, 0); cycle();
    chk("sr_4b", 32'(bus.Q), 32'h4B);
    drive(3'b010, 8'h00, 1'b0, 1'b0, 1'b0, 0); cycle();
    chk("sl_25", 32'(bus.Q), 32'h25);

    // Extended modes
    drive(3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 0); cycle();
    drive(3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 0); cycle();
    chk("ror_03", 32'(bus.Q), 32'h03);
    drive(3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 0); cycle();
    drive(3'b101, 8'h00, 1'b0, 1'b0, 1'b0, 0); cycle();
    chk("rol_c0", 32'(bus.Q), 32'hC0);
    drive(3'b011, 8'h90, 1'b0, 1'b0, 1'b0, 0); cycle();
    drive(3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 0); cycle();
    chk("asl_c8", 32'(bus.Q), 32'hC8);
    drive(3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 0); cycle();
    chk("clr_00", 32'(bus.Q), 32'h00);

    // Burst of 3 right shifts with S/D scrambled mid-burst
    drive(3'b011, 8'h01, 1'b0, 1'b0, 1'b0, 0); cycle();
    drive(3'b001, 8'h00, 1'b0, 1'b0, 1'b1, 3); cycle();
    chk("acc_hold", 32'(bus.Q), 32'h01);
    drive(3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) cycle();
    chk("burst_08", 32'(bus.Q), 32'h08);
    chk("burst_done", 32'(bus.Done), 32'h1);
    drive(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 0); cycle();

    // Zero count and non-shift mode: Start ignored
    drive(3'b001, 8'h00, 1'b0, 1'b0, 1'b1, 0); cycle();
    chk("cnt0_q", 32'(bus.Q), 32'h10);
    drive(3'b011, 8'h3C, 1'b0, 1'b0, 1'b1, 5); cycle();
    chk("ld_start", 32'(bus.Q), 32'h3C);

    // Start held high: second burst accepted in the Done cycle
    drive(3'b010, 8'h00, 1'b0, 1'b1, 1'b1, 2);
    repeat (7) cycle();
    drive(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) cycle();

    // Abort a rotate burst of 5 after two shifts
    drive(3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 0); cycle();
    drive(3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 5); cycle();
    drive(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) cycle();
    pulse_reset();
    repeat (4) cycle();
    drive(3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 1); cycle();
    chk("post_abort_busy", 32'(bus.Busy), 32'h1);
    drive(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) cycle();

    // Randomized traffic, including counts beyond WIDTH and occasional resets
    for (int n = 0; n < 400; n++) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
